// File: rtl/clip_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clip_pkg                                                                   |
// | Shared types and constants for the clip recorder front-panel controller.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package clip_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAYING   = 2'd1,
        RECORDING = 2'd2
    } clip_state_t;

    localparam int CLIP_WIDTH = 4;
    // The display driver blanks any value of 10 or more.
    localparam logic [CLIP_WIDTH-1:0] CLIP_BLANK = 4'hF;

    function automatic logic [CLIP_WIDTH-1:0] clip_next(
        input logic [CLIP_WIDTH-1:0] cur,
        input int                    num_clips
    );
        if (cur == CLIP_WIDTH'(num_clips - 1)) begin
            return '0;
        end
        return cur + CLIP_WIDTH'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clip_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clip_controller_if                                                         |
// | Front-panel buttons, audio-engine handshake and display clip numbers.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface clip_controller_if;
    import clip_pkg::*;

    logic                  btn_play_i;
    logic                  btn_record_i;
    logic                  btn_next_i;
    logic                  clip_done_i;
    logic                  play_start_o;
    logic                  record_start_o;
    logic                  stop_o;
    logic [CLIP_WIDTH-1:0] play_clip_o;
    logic [CLIP_WIDTH-1:0] record_clip_o;
    logic                  busy_o;

    // Controller side.
    modport master (
        input  btn_play_i, btn_record_i, btn_next_i, clip_done_i,
        output play_start_o, record_start_o, stop_o,
               play_clip_o, record_clip_o, busy_o
    );

    // Panel / audio-engine / display side.
    modport slave (
        output btn_play_i, btn_record_i, btn_next_i, clip_done_i,
        input  play_start_o, record_start_o, stop_o,
               play_clip_o, record_clip_o, busy_o
    );

endinterface
`default_nettype wire

// File: rtl/clip_controller_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | debounce                                                                   |
// | Two-flop synchroniser, stability counter and rising-edge press pulse.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module debounce #(
    parameter int CYCLES = 4
) (
    input  wire logic clock_i,
    input  wire logic reset_i,
    input  wire logic raw_i,
    output logic      level_o,
    output logic      press_o
);

    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             level_q, level_d;
    logic             prev_q, prev_d;
    logic             press_q, press_d;

    always_comb begin
        sync_d  = {sync_q[0], raw_i};
        level_d = level_q;
        count_d = '0;
        // A full count means CYCLES consecutive disagreeing samples were seen.
        if (count_q == CNT_W'(CYCLES)) begin
            level_d = ~level_q;
        end else if (sync_q[1] != level_q) begin
            count_d = count_q + CNT_W'(1);
        end
        prev_d  = level_q;
        press_d = level_q & ~prev_q;
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            sync_q  <= '0;
            count_q <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            count_q <= count_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/clip_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clip_controller                                                            |
// | Button debouncing, clip selection and IDLE/PLAYING/RECORDING control.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module clip_controller
    import clip_pkg::*;
#(
    parameter int SYSTEM_FREQUENCY   = 100000000,
    parameter int DEBOUNCE_FREQUENCY = 100,
    parameter int NUM_CLIPS          = 3
) (
    input  wire logic         clock_i,
    input  wire logic         reset_i,
    clip_controller_if.master bus
);

    localparam int DEBOUNCE_CYCLES = SYSTEM_FREQUENCY / DEBOUNCE_FREQUENCY;

    logic       w_play_press;
    logic       w_record_press;
    logic       w_next_press;
    logic [2:0] w_unused_level;

    debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_play (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .raw_i   (bus.btn_play_i),
        .level_o (w_unused_level[0]),
        .press_o (w_play_press)
    );

    debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_record (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .raw_i   (bus.btn_record_i),
        .level_o (w_unused_level[1]),
        .press_o (w_record_press)
    );

    debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .raw_i   (bus.btn_next_i),
        .level_o (w_unused_level[2]),
        .press_o (w_next_press)
    );

    clip_state_t           state_q, state_d;
    logic [CLIP_WIDTH-1:0] sel_q, sel_d;
    logic [CLIP_WIDTH-1:0] active_q, active_d;
    logic                  play_start_q, play_start_d;
    logic                  record_start_q, record_start_d;
    logic                  stop_q, stop_d;
    logic                  busy_q, busy_d;
    logic [CLIP_WIDTH-1:0] play_clip_q, play_clip_d;
    logic [CLIP_WIDTH-1:0] record_clip_q, record_clip_d;

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        active_d       = active_q;
        play_start_d   = 1'b0;
        record_start_d = 1'b0;
        stop_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_next_press) begin
                    sel_d = clip_next(sel_q, NUM_CLIPS);
                end
                // Play has priority over a simultaneous record press.
                if (w_play_press) begin
                    play_start_d = 1'b1;
                    active_d     = sel_q;
                    state_d      = PLAYING;
                end else if (w_record_press) begin
                    record_start_d = 1'b1;
                    active_d       = sel_q;
                    state_d        = RECORDING;
                end
            end
            PLAYING, RECORDING: begin
                // Engine completion beats a user abort arriving on the same edge.
                if (bus.clip_done_i) begin
                    state_d = IDLE;
                end else if (w_play_press || w_record_press) begin
                    stop_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);

        case (state_d)
            PLAYING: begin
                play_clip_d   = active_d;
                record_clip_d = CLIP_BLANK;
            end
            RECORDING: begin
                play_clip_d   = CLIP_BLANK;
                record_clip_d = active_d;
            end
            default: begin
                play_clip_d   = sel_d;
                record_clip_d = sel_d;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q        <= IDLE;
            sel_q          <= '0;
            active_q       <= '0;
            play_start_q   <= 1'b0;
            record_start_q <= 1'b0;
            stop_q         <= 1'b0;
            busy_q         <= 1'b0;
            play_clip_q    <= '0;
            record_clip_q  <= '0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            active_q       <= active_d;
            play_start_q   <= play_start_d;
            record_start_q <= record_start_d;
            stop_q         <= stop_d;
            busy_q         <= busy_d;
            play_clip_q    <= play_clip_d;
            record_clip_q  <= record_clip_d;
        end
    end

    assign bus.play_start_o   = play_start_q;
    assign bus.record_start_o = record_start_q;
    assign bus.stop_o         = stop_q;
    assign bus.busy_o         = busy_q;
    assign bus.play_clip_o    = play_clip_q;
    assign bus.record_clip_o  = record_clip_q;

endmodule
`default_nettype wire
